// File: rtl/ex_alu_pkg.sv
// ex_alu_pkg: shared ALUOp/funct encodings and ALU operation codes for the execute stage
package ex_alu_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_MUL = 3'b010,
      ALU_AND = 3'b011,
      ALU_OR  = 3'b100
   } alu_op_e;

endpackage

// File: rtl/ex_alu_if.sv
// ex_alu_if: operand/control inputs and result outputs of the execute-stage ALU block
interface ex_alu_if #(parameter int WIDTH = 32) ();

   logic             en_i;
   logic [1:0]       aluop_i;
   logic [5:0]       funct_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic [WIDTH-1:0] add_a_i;
   logic [WIDTH-1:0] add_b_i;
   logic [2:0]       aluctrl_o;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;
   logic [WIDTH-1:0] result_q_o;
   logic             zero_q_o;
   logic [WIDTH-1:0] sum_o;

   modport master (
      output en_i, aluop_i, funct_i, data1_i, data2_i, add_a_i, add_b_i,
      input  aluctrl_o, result_o, zero_o, result_q_o, zero_q_o, sum_o
   );

   modport slave (
      input  en_i, aluop_i, funct_i, data1_i, data2_i, add_a_i, add_b_i,
      output aluctrl_o, result_o, zero_o, result_q_o, zero_q_o, sum_o
   );

endinterface

// File: rtl/ex_alu_ctrl_dec.sv
// ex_alu_ctrl_dec: maps ALUOp plus funct to the 3-bit ALU operation
module ex_alu_ctrl_dec
   import ex_alu_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [5:0] funct_i,
   output logic [2:0] aluctrl_o
);

   alu_op_e funct_op;
   alu_op_e op;

   // unknown funct (including the all-zero flushed slot) and reserved ALUOp fall back to add
   always_comb begin
      funct_op = funct_i == FUNCT_ADD ? ALU_ADD :
                 funct_i == FUNCT_SUB ? ALU_SUB :
                 funct_i == FUNCT_MUL ? ALU_MUL :
                 funct_i == FUNCT_AND ? ALU_AND :
                 funct_i == FUNCT_OR  ? ALU_OR  : ALU_ADD;
      op = aluop_i == ALUOP_ADD   ? ALU_ADD :
           aluop_i == ALUOP_SUB   ? ALU_SUB :
           aluop_i == ALUOP_RTYPE ? funct_op : ALU_ADD;
      aluctrl_o = op;
   end

endmodule

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU with control decode, registered EX/M result and a standalone adder
module ex_alu_unit
   import ex_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic   clk_i,
   input  logic   rst_i,
   ex_alu_if.slave bus
);

   logic [2:0]       aluctrl;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic [WIDTH-1:0] result_d, result_q;
   logic             zero_d, zero_q;

   ex_alu_ctrl_dec u_dec (
      .aluop_i   (bus.aluop_i),
      .funct_i   (bus.funct_i),
      .aluctrl_o (aluctrl)
   );

   // codes 101-111 are unused and deliberately produce zero
   always_comb begin
      case (aluctrl)
         ALU_ADD: result = bus.data1_i + bus.data2_i;
         ALU_SUB: result = bus.data1_i - bus.data2_i;
         ALU_MUL: result = bus.data1_i * bus.data2_i;
         ALU_AND: result = bus.data1_i & bus.data2_i;
         ALU_OR:  result = bus.data1_i | bus.data2_i;
         default: result = '0;
      endcase
      zero     = result == '0;
      result_d = bus.en_i ? result : result_q;
      zero_d   = bus.en_i ? zero : zero_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.aluctrl_o  = aluctrl;
   assign bus.result_o   = result;
   assign bus.zero_o     = zero;
   assign bus.result_q_o = result_q;
   assign bus.zero_q_o   = zero_q;
   assign bus.sum_o      = bus.add_a_i + bus.add_b_i;

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: vector table for the combinational paths, scoreboard for the EX/M register
module tb_ex_alu_unit;

   typedef struct {
      logic [1:0]  aluop;
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] add_a;
      logic [31:0] add_b;
      logic [2:0]  exp_ctrl;
      logic [31:0] exp_res;
      logic        exp_zero;
      logic [31:0] exp_sum;
   } vec_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   vec_t vecs[13];
   logic [32:0] sb[$];
   logic [32:0] model_q;

   ex_alu_if #(.WIDTH(32)) bus ();

   ex_alu_unit #(.WIDTH(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] aluop, input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
      bus.aluop_i = aluop;
      bus.funct_i = funct;
      bus.data1_i = a;
      bus.data2_i = b;
   endtask

   task automatic cycle(input logic e, input logic [32:0] cap);
      bus.en_i = e;
      if (e) sb.push_back(cap);
      @(posedge clk);
      #1;
      if (sb.size() > 0) model_q = sb.pop_front();
      check("result_q", bus.result_q_o, model_q[31:0]);
      check("zero_q", {31'd0, bus.zero_q_o}, {31'd0, model_q[32]});
   endtask

   initial begin
      tests = 0;
      fails = 0;
      model_q = '0;
      rst = 1'b1;
      bus.en_i = 1'b0;
      bus.add_a_i = '0;
      bus.add_b_i = '0;
      drive(2'b10, 6'b100000, 32'd5, 32'd7);

      vecs[0]  = '{2'b10, 6'b100000, 32'd5,     32'd7,     32'h100,      32'd4, 3'b000, 32'd12,       1'b0, 32'h104};
      vecs[1]  = '{2'b10, 6'b100010, 32'd7,     32'd7,     32'hFFFFFFFC, 32'd4, 3'b001, 32'd0,        1'b1, 32'h0};
      vecs[2]  = '{2'b10, 6'b100010, 32'd0,     32'd1,     32'h20,       32'hC, 3'b001, 32'hFFFFFFFF, 1'b0, 32'h2C};
      vecs[3]  = '{2'b10, 6'b011000, 32'h10000, 32'h10000, 32'hFFFFFFFF, 32'd1, 3'b010, 32'd0,        1'b1, 32'h0};
      vecs[4]  = '{2'b10, 6'b011000, 32'd3,     32'hFFFFFFFE, 32'h1234,    32'h1, 3'b010, 32'hFFFFFFFA, 1'b0, 32'h1235};
      vecs[5]  = '{2'b10, 6'b100100, 32'hF0F0,  32'hFF00,  32'h0,        32'h0, 3'b011, 32'hF000,     1'b0, 32'h0};
      vecs[6]  = '{2'b10, 6'b100101, 32'hF0F0,  32'hFF00,  32'h7FFFFFFF, 32'd1, 3'b100, 32'hFFF0,     1'b0, 32'h80000000};
      vecs[7]  = '{2'b10, 6'b000000, 32'd5,     32'd7,     32'd8,        32'd8, 3'b000, 32'd12,       1'b0, 32'd16};
      vecs[8]  = '{2'b00, 6'b100010, 32'd5,     32'd7,     32'd1,        32'd2, 3'b000, 32'd12,       1'b0, 32'd3};
      vecs[9]  = '{2'b01, 6'b100000, 32'd5,     32'd7,     32'd3,        32'd4, 3'b001, 32'hFFFFFFFE, 1'b0, 32'd7};
      vecs[10] = '{2'b11, 6'b100010, 32'd5,     32'd7,     32'd5,        32'd5, 3'b000, 32'd12,       1'b0, 32'd10};
      vecs[11] = '{2'b10, 6'b111111, 32'd1,     32'd2,     32'h40,       32'h4, 3'b000, 32'd3,        1'b0, 32'h44};
      vecs[12] = '{2'b10, 6'b100100, 32'hF0,    32'h0F,    32'h0,        32'h0, 3'b011, 32'd0,        1'b1, 32'h0};

      #12;
      check("reset result_q", bus.result_q_o, 32'd0);
      check("reset zero_q", {31'd0, bus.zero_q_o}, 32'd0);
      check("comb under reset", bus.result_o, 32'd12);

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b);
         bus.add_a_i = vecs[i].add_a;
         bus.add_b_i = vecs[i].add_b;
         #2;
         check($sformatf("v%0d aluctrl", i), {29'd0, bus.aluctrl_o}, {29'd0, vecs[i].exp_ctrl});
         check($sformatf("v%0d result", i), bus.result_o, vecs[i].exp_res);
         check($sformatf("v%0d zero", i), {31'd0, bus.zero_o}, {31'd0, vecs[i].exp_zero});
         check($sformatf("v%0d sum", i), bus.sum_o, vecs[i].exp_sum);
      end
      check("regs held in reset", bus.result_q_o, 32'd0);

      @(negedge clk);
      rst = 1'b0;
      drive(2'b10, 6'b100000, 32'd5, 32'd7);
      cycle(1'b1, {1'b0, 32'd12});
      drive(2'b10, 6'b100010, 32'd7, 32'd7);
      cycle(1'b0, 33'd0);
      cycle(1'b1, {1'b1, 32'd0});
      drive(2'b10, 6'b011000, 32'd3, 32'd4);
      cycle(1'b1, {1'b0, 32'd12});

      #2;
      rst = 1'b1;
      sb.delete();
      model_q = '0;
      #1;
      check("async reset result_q", bus.result_q_o, 32'd0);
      check("async reset zero_q", {31'd0, bus.zero_q_o}, 32'd0);
      drive(2'b10, 6'b100000, 32'd9, 32'd1);
      bus.en_i = 1'b1;
      @(posedge clk);
      #1;
      check("reset over edge result_q", bus.result_q_o, 32'd0);
      check("reset over edge zero_q", {31'd0, bus.zero_q_o}, 32'd0);
      check("comb ignores reset", bus.result_o, 32'd10);

      @(negedge clk);
      rst = 1'b0;
      #1;
      check("released no capture", bus.result_q_o, 32'd0);
      cycle(1'b1, {1'b0, 32'd10});
      drive(2'b01, 6'b000000, 32'd4, 32'd4);
      cycle(1'b1, {1'b1, 32'd0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
- Execute-stage arithmetic block of the 5-stage MIPS-subset pipeline. It contains three functions:
  - ALU-control decode: ALUOp plus funct to a 3-bit ALU operation code.
  - 32-bit ALU.
  - Standalone 32-bit adder, used for PC+4 and for the branch target.
- ALU result and zero flag are available both combinationally and through a registered (EX/M) copy.

Parameters:
- WIDTH, 32, datapath width of ALU operands, result and adder.

Ports:
- clk_i, in, 1, clock; register updates on rising edge.
- rst_i, in, 1, asynchronous active-high reset.
- en_i, in, 1, register load enable; 0 holds the registered outputs.
- aluop_i, in, 2, 00 add, 01 sub, 10 R-type (decode funct), 11 reserved.
- funct_i, in, 6, instruction bits [5:0].
- data1_i, in, WIDTH, ALU operand A (rs path after forwarding).
- data2_i, in, WIDTH, ALU operand B (rt or sign-extended immediate).
- add_a_i, in, WIDTH, adder operand A.
- add_b_i, in, WIDTH, adder operand B.
- aluctrl_o, out, 3, decoded ALU operation.
- result_o, out, WIDTH, combinational ALU result.
- zero_o, out, 1, combinational; 1 when result_o == 0.
- result_q_o, out, WIDTH, registered result_o.
- zero_q_o, out, 1, registered zero_o.
- sum_o, out, WIDTH, combinational add_a_i + add_b_i.

Behaviour:
- ALU-control decode (combinational):
  - aluop 00 -> 000 (add).
  - aluop 01 -> 001 (sub).
  - aluop 11 -> 000 (add).
  - aluop 10 decodes funct:
    - 100000 -> 000 (add)
    - 100010 -> 001 (sub)
    - 011000 -> 010 (mul)
    - 100100 -> 011 (and)
    - 100101 -> 100 (or)
    - any other funct -> 000 (add). Funct 000000 (nop/flushed slot) therefore yields add.
- ALU (combinational):
  - 000: A+B.
  - 001: A-B, two's complement.
  - 010: low WIDTH bits of A*B.
  - 011: A&B.
  - 100: A|B.
  - 101-111: result 0.
  - Add, sub and mul wrap modulo 2^WIDTH; no overflow or carry output.
- zero_o = (result_o == 0), evaluated for every operation.
- Adder: sum_o = add_a_i + add_b_i modulo 2^WIDTH, purely combinational and independent of the ALU. Example: 0xFFFFFFFC + 4 = 0.
- Registers:
  - On rst_i high (asynchronous, any time): result_q_o = 0 and zero_q_o = 0.
  - Otherwise, at a rising clock edge with en_i = 1: result_q_o and zero_q_o take result_o and zero_o. Latency is 1 cycle.
  - en_i = 0 holds both registered outputs.
  - Reset asserted together with a clock edge: reset wins.
  - Reset deasserting mid-operation: the first capture is at the next enabled edge.
- Combinational outputs are unaffected by rst_i and en_i.
- No X propagation from unused aluctrl codes: defaults are always driven.

Decomposition:
- Shared package ex_alu_pkg holds:
  - ALUOp constants (ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_RTYPE = 10).
  - Funct constants (FUNCT_ADD = 100000, FUNCT_SUB = 100010, FUNCT_MUL = 011000, FUNCT_AND = 100100, FUNCT_OR = 100101).
  - 3-bit ALU op enum (ADD = 000, SUB = 001, MUL = 010, AND = 011, OR = 100).
- One natural sub-module: ex_alu_ctrl_dec (aluop/funct -> aluctrl). ALU, adder and registers stay in the top.

Test Plan:
- R-type add, sub and zero flag:
  - aluop 10, funct 100000, A = 5, B = 7 -> aluctrl 000, result 12, zero 0.
  - funct 100010, A = 7, B = 7 -> result 0, zero 1.
- Wrap-around:
  - sub, A = 0, B = 1 -> 0xFFFFFFFF.
  - mul, A = 0x10000, B = 0x10000 -> 0.
  - mul, A = 3, B = -2 -> 0xFFFFFFFA.
- Logic and default decode:
  - funct 100100, A = 0xF0F0, B = 0xFF00 -> 0xF000.
  - funct 100101, same operands -> 0xFFF0.
  - funct 000000 -> add.
  - aluop 00 -> add; aluop 01 -> sub (5 - 7 = 0xFFFFFFFE); aluop 11 -> add.
- Adder:
  - 0x00000100 + 4 -> 0x00000104.
  - 0xFFFFFFFC + 4 -> 0x00000000.
  - Branch target: 0x20 + (3<<2) -> 0x2C.
- Registered path:
  - add 5 + 7 with en 1 -> result_q 12 one edge later.
  - en 0, inputs changed -> result_q stays 12.
  - en 1 with operands making result 0 -> zero_q 1 after the edge.
- Reset:
  - Assert rst_i between edges -> result_q 0 and zero_q 0 immediately.
  - Hold rst_i across an enabled edge -> outputs stay 0.
  - After release, the next enabled edge captures.
